fetch_aligner: RTL and testbench

- Sits between instruction memory/fetch and `decompressor`.
- Accepts 32-bit aligned fetch words via valid/ready. Extracts instructions, each either a 16-bit compressed parcel or a 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Presents one instruction per cycle, with its PC, through a registered output stage.
- The `[15:0]` bits of a compressed output feed the `decompressor` input directly.

---
 rtl/fetch_aligner_pkg.sv | 19 +
 rtl/fetch_aligner_if.sv | 37 +++
 rtl/fetch_aligner.sv | 129 ++++++++++++
 tb/tb_fetch_aligner.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_aligner_pkg.sv
// Shared types for the fetch aligner.
// FETCH_ALIGNER_RVC_EN selects 16-bit parcel support.
package fetch_aligner_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [1:0] ALIGN_OPCODE_FULL = 2'b11;

`ifdef FETCH_ALIGNER_RVC_EN
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
`endif

  function automatic logic is_full(halfword_t h);
    return h[1:0] == ALIGN_OPCODE_FULL;
  endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Fetch-word input and instruction output handshakes.
// master drives words/out_ready, slave is the aligner.
interface fetch_aligner_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_compressed;
  logic [31:0] out_pc;

  modport master (
    output in_valid,
    output in_word,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_compressed,
    input  out_pc
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_compressed,
    output out_pc
  );

endinterface

// File: rtl/fetch_aligner.sv
// Splits 32-bit fetch words into RV32/RVC instructions with PCs.
// Define FETCH_ALIGNER_RVC_EN for compressed support (else RV32I only).
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [31:0]     flush_pc,
  fetch_aligner_if.slave  io
);

  logic        adv;
  logic        cand_valid;
  logic [31:0] cand_instr;
  logic        cand_comp;
  logic        rdy;
  logic [31:0] next_pc;
  logic [31:0] step;
  logic        unused_pc;

  assign adv       = !io.out_valid || io.out_ready;
  assign step      = cand_comp ? 32'd2 : 32'd4;
  assign unused_pc = ^flush_pc[1:0];

  assign io.in_ready = rdy && !flush && !reset;

`ifdef FETCH_ALIGNER_RVC_EN
  halfword_t hbuf;
  logic      hbuf_valid;
  logic      skip_low;
  logic      hbuf_load;
  logic      hbuf_drop;
  logic      accept;
  logic      issue;

  assign accept = io.in_valid && io.in_ready;
  assign issue  = adv && cand_valid && !flush;

  always_comb begin
    cand_valid = 1'b0;
    cand_instr = '0;
    cand_comp  = 1'b0;
    rdy        = 1'b0;
    hbuf_load  = 1'b0;
    hbuf_drop  = 1'b0;
    unique case (1'b1)
      hbuf_valid && !is_full(hbuf): begin
        cand_valid = 1'b1;
        cand_instr = {16'h0, hbuf};
        cand_comp  = 1'b1;
        hbuf_drop  = 1'b1;
      end
      hbuf_valid && is_full(hbuf): begin
        cand_valid = io.in_valid;
        cand_instr = {io.in_word[15:0], hbuf};
        rdy        = adv;
        hbuf_load  = 1'b1;
      end
      // out_valid is always low here, so adv is 1
      !hbuf_valid && skip_low: begin
        rdy       = adv;
        hbuf_load = 1'b1;
      end
      !hbuf_valid && !skip_low
        && !is_full(io.in_word[15:0]): begin
        cand_valid = io.in_valid;
        cand_instr = {16'h0, io.in_word[15:0]};
        cand_comp  = 1'b1;
        rdy        = adv;
        hbuf_load  = 1'b1;
      end
      default: begin
        cand_valid = io.in_valid;
        cand_instr = io.in_word;
        rdy        = adv;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hbuf       <= '0;
      hbuf_valid <= 1'b0;
      skip_low   <= RESET_PC[1];
    end else if (flush) begin
      hbuf_valid <= 1'b0;
      skip_low   <= flush_pc[1];
    end else if (accept && hbuf_load) begin
      hbuf       <= io.in_word[31:16];
      hbuf_valid <= 1'b1;
      skip_low   <= 1'b0;
    end else if (issue && hbuf_drop) begin
      hbuf_valid <= 1'b0;
    end
  end
`else
  always_comb begin
    cand_valid = io.in_valid;
    cand_instr = io.in_word;
    cand_comp  = 1'b0;
    rdy        = adv;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.out_valid      <= 1'b0;
      io.out_instr      <= '0;
      io.out_compressed <= 1'b0;
      io.out_pc         <= RESET_PC;
      next_pc           <= RESET_PC & PC_ALIGN_MASK;
    end else if (flush) begin
      io.out_valid <= 1'b0;
      next_pc      <= flush_pc & PC_ALIGN_MASK;
    end else if (adv) begin
      io.out_valid <= cand_valid;
      if (cand_valid) begin
        io.out_instr      <= cand_instr;
        io.out_compressed <= cand_comp;
        io.out_pc         <= next_pc;
        next_pc           <= next_pc + step;
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Randomized bench for fetch_aligner against a program-memory
// parse model; directed literal cases pin the model.
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;

  fetch_aligner_if io();

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .flush_pc (flush_pc),
    .io       (io)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int issued = 0;
  int valid_pct = 100;
  int ready_pct = 100;

  logic [31:0] mem [256];
  logic [31:0] fetch_addr;
  logic [31:0] model_pc;
  ent_t        log_q [$];

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] p);
`ifdef FETCH_ALIGNER_RVC_EN
    return p & 32'hFFFF_FFFE;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Next instruction in program order starting at p
  function automatic ent_t model_at(input logic [31:0] p);
    ent_t e;
    logic [15:0] h;
    e.pc = 32'd4;
`ifdef FETCH_ALIGNER_RVC_EN
    h = half_at(p);
    if (h[1:0] != 2'b11) begin
      e.instr = {16'h0, h};
      e.comp  = 1'b1;
      e.pc    = 32'd2;
    end else begin
      e.instr = {half_at(p + 32'd2), h};
      e.comp  = 1'b0;
    end
`else
    h = 16'h0;
    e.instr = mem[p[9:2]];
    e.comp  = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [15:0] h [2];
    for (int k = 0; k < 2; k++) begin
      h[k] = 16'($urandom);
      if ($urandom_range(1) == 1) h[k][1:0] = 2'b11;
      else if (h[k][1:0] == 2'b11) h[k][1:0] = 2'b01;
    end
    return {h[1], h[0]};
  endfunction

  logic        prev_stall = 1'b0;
  logic        prev_kill  = 1'b0;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        s_comp;

  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      chk("rst_out_valid", 32'(io.out_valid), 32'd0);
      chk("rst_in_ready", 32'(io.in_ready), 32'd0);
      chk("rst_out_instr", io.out_instr, 32'd0);
      chk("rst_out_comp", 32'(io.out_compressed), 32'd0);
      chk("rst_out_pc", io.out_pc, RESET_PC);
      model_pc   = align_pc(RESET_PC);
      prev_stall = 1'b0;
      prev_kill  = 1'b0;
    end else begin
      if (prev_kill)
        chk("flush_kill", 32'(io.out_valid), 32'd0);
      if (flush)
        chk("flush_in_ready", 32'(io.in_ready), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(io.out_valid), 32'd1);
        chk("hold_instr", io.out_instr, s_instr);
        chk("hold_pc", io.out_pc, s_pc);
        chk("hold_comp", 32'(io.out_compressed), 32'(s_comp));
      end
      if (io.out_valid && !io.out_ready)
        chk("stall_in_ready", 32'(io.in_ready), 32'd0);
      if (io.out_valid) begin
        e = model_at(model_pc);
        chk("instr", io.out_instr, e.instr);
        chk("comp", 32'(io.out_compressed), 32'(e.comp));
        chk("pc", io.out_pc, model_pc);
        if (io.out_ready) begin
          log_q.push_back('{io.out_instr, io.out_compressed, io.out_pc});
          model_pc = model_pc + e.pc;
          issued++;
        end
      end
      prev_stall = io.out_valid && !io.out_ready && !flush;
      s_instr    = io.out_instr;
      s_pc       = io.out_pc;
      s_comp     = io.out_compressed;
      prev_kill  = flush;
      if (flush) model_pc = align_pc(flush_pc);
    end
  end

  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = io.in_valid && io.in_ready;
    @(posedge clk);
    #1;
    if (reset) fetch_addr = RESET_PC & 32'hFFFF_FFFC;
    else if (flush) fetch_addr = flush_pc & 32'hFFFF_FFFC;
    else if (acc) fetch_addr = fetch_addr + 32'd4;
    flush = 1'b0;
    io.in_valid  = ($urandom_range(99) < valid_pct);
    io.in_word   = io.in_valid ? mem[fetch_addr[9:2]] : $urandom;
    io.out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
  endtask

  task automatic wait_issue(output ent_t e);
    int k;
    k = 0;
    while (log_q.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    chk("issue_timeout", 32'(log_q.size() > 0), 32'd1);
    if (log_q.size() > 0) e = log_q.pop_front();
    else e = '{32'hDEAD_DEAD, 1'b1, 32'hDEAD_DEAD};
  endtask

  initial begin
    ent_t e;
    ent_t m;
    logic [31:0] sv_instr;
    logic [31:0] sv_pc;
    logic        sv_comp;
    int          start;

    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    mem[0]  = 32'h00A0_0093;
    mem[1]  = 32'h4011_4505;
    mem[2]  = 32'h0093_4505;
    mem[3]  = 32'h4505_0050;
    mem[64] = 32'h4505_BEEF;
    mem[80] = 32'h0093_4505;

    reset        = 1'b1;
    flush        = 1'b0;
    flush_pc     = '0;
    io.in_valid  = 1'b0;
    io.in_word   = '0;
    io.out_ready = 1'b0;
    fetch_addr   = '0;

`ifdef FETCH_ALIGNER_RVC_EN
    m = model_at(32'h4);
    chk("model_c_4", m.instr, 32'h0000_4505);
    m = model_at(32'hA);
    chk("model_straddle_A", m.instr, 32'h0050_0093);
`else
    m = model_at(32'h4);
    chk("model_w_4", m.instr, 32'h4011_4505);
`endif

    repeat (3) tick();
    reset = 1'b0;
    log_q.delete();

    wait_issue(e);
    chk("d_addi_instr", e.instr, 32'h00A0_0093);
    chk("d_addi_comp", 32'(e.comp), 32'd0);
    chk("d_addi_pc", e.pc, 32'h0);
`ifdef FETCH_ALIGNER_RVC_EN
    wait_issue(e);
    chk("d_c0_instr", e.instr, 32'h0000_4505);
    chk("d_c0_pc", e.pc, 32'h4);
    wait_issue(e);
    chk("d_c1_instr", e.instr, 32'h0000_4011);
    chk("d_c1_comp", 32'(e.comp), 32'd1);
    chk("d_c1_pc", e.pc, 32'h6);
    wait_issue(e);
    chk("d_c2_pc", e.pc, 32'h8);
    wait_issue(e);
    chk("d_strad_instr", e.instr, 32'h0050_0093);
    chk("d_strad_comp", 32'(e.comp), 32'd0);
    chk("d_strad_pc", e.pc, 32'hA);
    wait_issue(e);
    chk("d_tail_instr", e.instr, 32'h0000_4505);
    chk("d_tail_pc", e.pc, 32'hE);
`else
    wait_issue(e);
    chk("d_w1_instr", e.instr, 32'h4011_4505);
    chk("d_w1_pc", e.pc, 32'h4);
    wait_issue(e);
    chk("d_w2_pc", e.pc, 32'h8);
    wait_issue(e);
    chk("d_w3_instr", e.instr, 32'h4505_0050);
    chk("d_w3_pc", e.pc, 32'hC);
`endif

    ready_pct = 0;
    tick();
    tick();
    sv_instr = io.out_instr;
    sv_pc    = io.out_pc;
    sv_comp  = io.out_compressed;
    chk("bp_valid_start", 32'(io.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(io.out_valid), 32'd1);
      chk("bp_instr", io.out_instr, sv_instr);
      chk("bp_pc", io.out_pc, sv_pc);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    end
    log_q.delete();
    ready_pct = 100;
    repeat (12) tick();
    wait_issue(e);
    chk("bp_resume_pc", e.pc, sv_pc);
    wait_issue(e);
    chk("bp_next_pc", e.pc, sv_pc + (sv_comp ? 32'd2 : 32'd4));

    do_flush(32'h0000_0102);
    log_q.delete();
    wait_issue(e);
`ifdef FETCH_ALIGNER_RVC_EN
    chk("fl_instr", e.instr, 32'h0000_4505);
    chk("fl_comp", 32'(e.comp), 32'd1);
    chk("fl_pc", e.pc, 32'h0000_0102);
`else
    chk("fl_instr", e.instr, 32'h4505_BEEF);
    chk("fl_pc", e.pc, 32'h0000_0100);
`endif

    ready_pct = 0;
    do_flush(32'h0000_0140);
    tick();
    tick();
    chk("pre_rst_valid", 32'(io.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(io.out_valid), 32'd0);
    chk("rst_async_in_ready", 32'(io.in_ready), 32'd0);
    ready_pct = 100;
    tick();
    tick();
    reset = 1'b0;
    log_q.delete();
    wait_issue(e);
    chk("post_rst_pc", e.pc, RESET_PC);
    chk("post_rst_instr", e.instr, 32'h00A0_0093);

    do_flush(32'hFFFF_FFF8);
    repeat (20) tick();

    for (int seg = 0; seg < 40; seg++) begin
      valid_pct = $urandom_range(30, 100);
      ready_pct = $urandom_range(30, 100);
      repeat (60) begin
        tick();
        if ($urandom_range(39) == 0) do_flush($urandom);
      end
    end

    valid_pct = 100;
    ready_pct = 100;
    start = issued;
    for (int k = 0; k < 200 && issued < start + 20; k++) tick();
    chk("progress", 32'(issued >= start + 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
